rgb444_to_gray: RTL
===================

RGB444_TO_GRAY -- requirements
Module: rgb444_to_gray

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, giving output pixels per line, used for gray_eol.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge triggered.
REQ-003 SHALL have port resetn, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port pix_byte, input, 8, camera byte stream; pixel byte0 = {xxxx,R[3:0]}, byte1 = {G[3:0],B[3:0]}.
REQ-005 SHALL have port pix_byte_valid, input, 1, pix_byte valid this cycle.
REQ-006 SHALL have port pix_byte_ready, output, 1, block accepts pix_byte this cycle.
REQ-007 SHALL have port frame_start, input, 1, single-cycle pulse marking start of a new frame.
REQ-008 SHALL have port gray_out, output, 8, grayscale pixel.
REQ-009 SHALL have port gray_valid, output, 1, gray_out/gray_eol valid.
REQ-010 SHALL have port gray_ready, input, 1, downstream accepts the output pixel.
REQ-011 SHALL have port gray_eol, output, 1, the output pixel is the last of its line.

Function
REQ-012 SHALL accept a byte only on a cycle where pix_byte_valid and pix_byte_ready are both high.
REQ-013 SHALL run a byte-phase FSM with two states: PH_HI (expects byte0) and PH_LO (expects byte1).
REQ-014 SHALL, in PH_HI on accept, latch R = pix_byte[3:0] and move to PH_LO.
REQ-015 SHALL, in PH_LO on accept, form the pixel {R, G = pix_byte[7:4], B = pix_byte[3:0]}, load it into pipeline stage 1, and return to PH_HI.
REQ-016 SHALL expand each channel to 8 bits by nibble replication (R8 = {R,R}, likewise G8 and B8).
REQ-017 SHALL compute gray_out = (77*R8 + 150*G8 + 29*B8 + 128) >> 8 using a 16-bit unsigned sum; the result never exceeds 255 and SHALL NOT be saturated or clipped.
REQ-018 SHALL use a 2-stage pipeline: stage 1 registers the pixel and column tag, stage 2 registers the sum result to gray_out.
REQ-019 SHALL assert gray_valid at the second rising edge after the edge accepting byte1, provided gray_ready is high throughout.
REQ-020 SHALL advance the pipeline only when gray_valid is low or gray_ready is high.
REQ-021 SHALL, while stalled, hold gray_out, gray_valid and gray_eol stable.
REQ-022 SHALL drive pix_byte_ready = resetn AND (stage 1 empty OR pipeline advancing); it is combinational with no bubble at full throughput.
REQ-023 SHALL sustain one byte per cycle, i.e. one pixel per 2 cycles, with no loss, duplication or reordering under any gray_ready pattern.
REQ-024 SHALL keep a column counter that increments per formed pixel and wraps from H_ACTIVE-1 to 0; the pixel formed at count H_ACTIVE-1 carries eol=1 through the pipeline into gray_eol.
REQ-025 SHALL, on frame_start, force PH_HI (discarding any latched orphan byte0) and clear the column counter.
REQ-026 SHALL leave pixels already in the pipeline unaffected by frame_start and deliver them normally.
REQ-027 SHALL, when frame_start coincides with a byte accept, treat that byte as byte0 of the new frame.

Reset
REQ-028 SHALL, while resetn is low at a clock edge, set gray_out=0, gray_valid=0, gray_eol=0, phase=PH_HI, column counter=0, and the pipeline empty.
REQ-029 SHALL hold pix_byte_ready at 0 while resetn is low and at 1 in the first cycle after release.
REQ-030 SHALL, on reset mid-operation, drop all in-flight pixels and the latched byte0, with no output pulse afterwards.

Verification
REQ-031 SHALL cover pure-channel inputs, gray_ready=1:
- 0x0F,0x00 -> 0x4D
- 0x00,0xF0 -> 0x95
- 0x00,0x0F -> 0x1D
- each appears 2 edges after byte1.
REQ-032 SHALL cover extremes: 0x0F,0xFF -> 0xFF; 0x00,0x00 -> 0x00; back-to-back bytes -> gray_valid every 2nd cycle.
REQ-033 SHALL cover backpressure: stream 4 pixels, gray_ready low for 5 cycles mid-stream -> outputs held stable, pix_byte_ready drops, all 4 delivered in order.
REQ-034 SHALL cover frame_start alignment: byte0 0x0F, then frame_start, then 0x00,0xF0 -> a single output 0x95 with the orphan byte discarded.
REQ-035 SHALL cover end-of-line: H_ACTIVE=4, 9 pixels -> gray_eol on output pixels 4 and 8 only; frame_start after pixel 2 -> the next eol falls on the 4th pixel after frame_start.
REQ-036 SHALL cover reset mid-stream: resetn low 1 cycle with 2 pixels in flight -> gray_valid=0 and no stale output after release.

Source files
------------

// File: rtl/rgb444_to_gray.sv
// Converts a two-byte-per-pixel RGB444 camera stream to 8-bit grayscale through a
// two-stage valid/ready pipeline, tagging the last pixel of each line.
module rgb444_to_gray #(
  parameter int unsigned H_ACTIVE = 640
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] pix_byte,
  input  logic       pix_byte_valid,
  output logic       pix_byte_ready,
  input  logic       frame_start,
  output logic [7:0] gray_out,
  output logic       gray_valid,
  input  logic       gray_ready,
  output logic       gray_eol
);

  localparam int unsigned ColW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(H_ACTIVE - 1);

  typedef enum logic {PhHi, PhLo} phase_e;

  phase_e          phase_q, phase_d;
  logic [3:0]      r_q, r_d;
  logic [ColW-1:0] col_q, col_d;

  logic            s1_valid_q;
  logic [11:0]     s1_pix_q;
  logic            s1_eol_q;

  logic [7:0]      gray_out_q;
  logic            gray_valid_q;
  logic            gray_eol_q;

  logic            advance;
  logic            accept;
  logic            form;
  logic [7:0]      r8, g8, b8;
  logic [15:0]     sum;

  always_comb begin
    advance        = !gray_valid_q || gray_ready;
    pix_byte_ready = resetn && (!s1_valid_q || advance);
    accept         = pix_byte_valid && pix_byte_ready;
    // A byte arriving with frame_start is always byte0 of the new frame.
    form           = accept && (phase_q == PhLo) && !frame_start;

    phase_d = phase_q;
    r_d     = r_q;
    col_d   = col_q;
    if (frame_start) begin
      phase_d = PhHi;
      col_d   = '0;
    end
    if (accept) begin
      if (frame_start || (phase_q == PhHi)) begin
        r_d     = pix_byte[3:0];
        phase_d = PhLo;
      end else begin
        phase_d = PhHi;
        col_d   = (col_q == ColMax) ? '0 : col_q + 1'b1;
      end
    end
  end

  always_comb begin
    r8  = {s1_pix_q[11:8], s1_pix_q[11:8]};
    g8  = {s1_pix_q[7:4], s1_pix_q[7:4]};
    b8  = {s1_pix_q[3:0], s1_pix_q[3:0]};
    // Weights sum to 256, so the rounded result tops out at 255 without clipping.
    sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8} + 16'd128;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q      <= PhHi;
      r_q          <= '0;
      col_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_pix_q     <= '0;
      s1_eol_q     <= 1'b0;
      gray_out_q   <= '0;
      gray_valid_q <= 1'b0;
      gray_eol_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      r_q     <= r_d;
      col_q   <= col_d;

      if (form) begin
        s1_valid_q <= 1'b1;
        s1_pix_q   <= {r_q, pix_byte};
        s1_eol_q   <= (col_q == ColMax);
      end else if (advance) begin
        s1_valid_q <= 1'b0;
      end

      if (advance) begin
        gray_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          gray_out_q <= sum[15:8];
          gray_eol_q <= s1_eol_q;
        end
      end
    end
  end

  assign gray_out   = gray_out_q;
  assign gray_valid = gray_valid_q;
  assign gray_eol   = gray_eol_q;

endmodule
